// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer for a synchronous-read instruction
// memory with one cycle of read latency. It owns the PC, issues at most one
// read per cycle, and keeps returning words in a small FIFO. Decode sees the
// FIFO head as a valid/ready stream. Execute can redirect the fetch stream.
//
// Optional feature: define FETCH_BOUNDS_CHK_EN to enable the fetch window
// bounds check. An address outside [IMEM_BASE, IMEM_BASE+IMEM_SIZE) is then
// never issued. Instead, fetch_fault sets and stays set until a redirect to
// an in-range target or a reset. Without the macro, fetch_fault is tied to 0.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   fetch_en        allows new reads to be issued
//   redirect_valid  one-cycle redirect strobe; redirect_pc is the target
//                   (bits [1:0] ignored)
//   imem_rd/addr    read strobe and word-aligned byte address to memory
//   imem_instr      read data, valid the cycle after imem_rd
//   instr_valid/ready/instr/instr_pc  FIFO head handshake towards decode
//   fetch_fault     sticky bounds fault
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0100_0000,
  parameter int          DEPTH     = 2,
  parameter logic [31:0] IMEM_BASE = 32'h0100_0000,
  parameter logic [31:0] IMEM_SIZE = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_rd,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        fetch_fault
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
      $error("fetch_ctrl: DEPTH must be a power of two and at least 2");
    end
    if (IMEM_SIZE == 32'd0 || IMEM_SIZE[1:0] != 2'b00 || IMEM_BASE[1:0] != 2'b00) begin : g_window_chk
      $error("fetch_ctrl: fetch window must be non-empty and word aligned");
    end
  endgenerate

  logic [31:0]   pc;
  logic          inflight;
  logic [31:0]   inflight_pc;
  logic [31:0]   fifo_instr [DEPTH];
  logic [31:0]   fifo_pc    [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] occ;

  logic          pop;
  logic          push;
  logic          want;
  logic          issue;
  logic [31:0]   tgt;
  logic [31:0]   issue_addr;
  logic [CW-1:0] committed;

`ifdef FETCH_BOUNDS_CHK_EN
  logic fault;
  logic fault_set;
  logic fault_clr;

  function automatic logic in_window(input logic [31:0] a);
    logic [31:0] off;
    off = a - IMEM_BASE;
    return (a >= IMEM_BASE) && (off < IMEM_SIZE);
  endfunction
`endif

  assign instr_valid = (occ != '0);
  // A redirect voids any handshake with the (about to be flushed) head.
  assign pop  = instr_valid & instr_ready & ~redirect_valid;
  assign push = inflight & ~redirect_valid;

  // Issue stage: decide whether a read goes out this cycle and where.
  always_comb begin
    tgt        = {redirect_pc[31:2], 2'b00};
    // Slots already promised: stored words plus the word still in flight,
    // less the one leaving this cycle. A new read needs a free slot.
    committed  = occ + CW'(inflight) - CW'(pop);
    want       = fetch_en & (committed < DEPTH_C);
    issue_addr = pc;
    issue      = 1'b0;
`ifdef FETCH_BOUNDS_CHK_EN
    fault_set  = 1'b0;
    fault_clr  = 1'b0;
    if (redirect_valid) begin
      // The FIFO is flushed, so only the window check can block a redirect.
      issue_addr = tgt;
      issue      = fetch_en & in_window(tgt);
      fault_clr  = in_window(tgt);
      fault_set  = fetch_en & ~in_window(tgt);
    end else begin
      issue      = want & ~fault & in_window(pc);
      fault_set  = want & ~in_window(pc);
    end
`else
    if (redirect_valid) begin
      issue_addr = tgt;
      issue      = fetch_en;
    end else begin
      issue      = want;
    end
`endif
    // The read strobe must stay low while reset is held, with no clock edge.
    issue = issue & rst_n;
  end

  assign imem_rd   = issue;
  assign imem_addr = {issue_addr[31:2], 2'b00};

  // ---- issue -> response boundary: PC, in-flight flag, FIFO control ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
    end else begin
      inflight <= issue;
      if (redirect_valid) begin
        pc <= issue ? tgt + 32'd4 : tgt;
      end else if (issue) begin
        pc <= pc + 32'd4;
      end
      if (redirect_valid) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        occ    <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        occ <= occ + CW'(push) - CW'(pop);
      end
    end
  end

  // ---- response -> FIFO boundary: data storage, no reset needed ----
  always_ff @(posedge clk) begin
    if (issue) inflight_pc <= issue_addr;
    if (push) begin
      fifo_instr[wr_ptr] <= imem_instr;
      fifo_pc[wr_ptr]    <= inflight_pc;
    end
  end

  // Gating on instr_valid drives zeros while empty, including during reset.
  assign instr    = instr_valid ? fifo_instr[rd_ptr] : 32'd0;
  assign instr_pc = instr_valid ? fifo_pc[rd_ptr]    : 32'd0;

`ifdef FETCH_BOUNDS_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault <= 1'b0;
    end else if (fault_clr) begin
      fault <= 1'b0;
    end else if (fault_set) begin
      fault <= 1'b1;
    end
  end

  assign fetch_fault = fault;
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed and randomized bench for fetch_ctrl. The bench
// plays the instruction memory. A queue-based reference model predicts the
// read address and the head of the decode stream every cycle.
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0100_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] BASE     = 32'h0100_0000;
  localparam logic [31:0] SIZE     = 32'h0000_1000;
`ifdef FETCH_BOUNDS_CHK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        imem_rd;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr = 32'd0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fetch_fault;

  fetch_ctrl #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH),
    .IMEM_BASE(BASE),
    .IMEM_SIZE(SIZE)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_en      (fetch_en),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_rd       (imem_rd),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .fetch_fault   (fetch_fault)
  );

  always #5 clk = ~clk;

  // Memory contents: a bijective scramble of the address, so each word is unique.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h3C5A_96E1;
  endfunction

  // Synchronous-read memory; the output register holds when rd is low.
  always @(posedge clk) begin
    if (imem_rd) imem_instr <= memf(imem_addr);
  end

  // Reference model state.
  logic [31:0] m_pc;
  bit          m_infl;
  logic [31:0] m_infl_pc;
  logic [63:0] m_q[$];
  bit          m_fault;

  int          total = 0;
  int          bad = 0;
  logic        obs_rd;
  logic [31:0] obs_addr;
  logic [31:0] hp;
  int          rd_count;

  function automatic bit in_win(input logic [31:0] a);
    logic [63:0] x;
    logic [63:0] lo;
    logic [63:0] hi;
    x  = {32'd0, a};
    lo = {32'd0, BASE};
    hi = {32'd0, BASE} + {32'd0, SIZE};
    return (x >= lo) && (x < hi);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = RESET_PC;
    m_infl  = 1'b0;
    m_infl_pc = 32'd0;
    m_q.delete();
    m_fault = 1'b0;
  endtask

  // One clock cycle: drive inputs, check predicted outputs, advance the model.
  // Entered and left just after a falling edge.
  task automatic step(input bit fe, input bit rdy, input bit rv, input logic [31:0] rpc);
    bit          e_rd;
    bit          pop;
    bit          room;
    logic [31:0] e_addr;
    logic [31:0] tgt;
    fetch_en       = fe;
    instr_ready    = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    pop  = (m_q.size() != 0) && rdy && !rv;
    room = (m_q.size() + int'(m_infl) - int'(pop)) < DEPTH;
    tgt  = {rpc[31:2], 2'b00};
    if (rv) begin
      e_addr = tgt;
      e_rd   = fe && (!BOUNDS || in_win(tgt));
    end else begin
      e_addr = m_pc;
      e_rd   = fe && room && !m_fault && (!BOUNDS || in_win(m_pc));
    end
    obs_rd   = imem_rd;
    obs_addr = imem_addr;
    chk("imem_rd", {31'd0, imem_rd}, {31'd0, e_rd});
    if (e_rd) chk("imem_addr", imem_addr, e_addr);
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_q.size() != 0});
    if (m_q.size() != 0) begin
      chk("instr", instr, m_q[0][63:32]);
      chk("instr_pc", instr_pc, m_q[0][31:0]);
    end
    chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
    @(posedge clk);
    if (BOUNDS) begin
      if (rv && in_win(tgt))            m_fault = 1'b0;
      else if (rv && fe)                m_fault = 1'b1;
      else if (!rv && fe && room && !in_win(m_pc)) m_fault = 1'b1;
    end
    if (rv) begin
      m_q.delete();
    end else begin
      if (pop) void'(m_q.pop_front());
      if (m_infl) m_q.push_back({memf(m_infl_pc), m_infl_pc});
    end
    if (rv)        m_pc = e_rd ? tgt + 32'd4 : tgt;
    else if (e_rd) m_pc = m_pc + 32'd4;
    m_infl    = e_rd;
    m_infl_pc = e_addr;
    @(negedge clk);
  endtask

  initial begin
    // Reset state: outputs quiet while reset is held, even with fetch_en high.
    model_reset();
    fetch_en = 1'b1;
    instr_ready = 1'b1;
    #1;
    chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_imem_rd", {31'd0, imem_rd}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential fetch and two-cycle latency to the first valid word.
    step(1, 1, 0, 0);
    chk("t1_first_addr", obs_addr, 32'h0100_0000);
    chk("t1_no_valid_n1", {31'd0, instr_valid}, 32'd0);
    step(1, 1, 0, 0);
    chk("t1_second_addr", obs_addr, 32'h0100_0004);
    chk("t1_valid_n2", {31'd0, instr_valid}, 32'd1);
    chk("t1_first_pc", instr_pc, 32'h0100_0000);
    chk("t1_first_instr", instr, memf(32'h0100_0000));
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0);

    // Backpressure: head holds, outstanding words stay within DEPTH.
    hp = m_q[0][31:0];
    rd_count = 0;
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0);
      rd_count += int'(obs_rd);
    end
    chk("t2_head_held", instr_pc, hp);
    chk("t2_reads_bounded", {31'd0, rd_count <= DEPTH}, 32'd1);
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0);

    // Redirect with a non-empty FIFO and a read in flight.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 1, 32'h0100_0103);
    chk("t3_redir_rd", {31'd0, obs_rd}, 32'd1);
    chk("t3_redir_addr", obs_addr, 32'h0100_0100);
    chk("t3_flushed", {31'd0, instr_valid}, 32'd0);
    step(1, 1, 0, 0);
    chk("t3_new_valid", {31'd0, instr_valid}, 32'd1);
    chk("t3_new_pc", instr_pc, 32'h0100_0100);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0);

    // fetch_en low: in-flight word still delivered, no new reads.
    rd_count = 0;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0);
      rd_count += int'(obs_rd);
    end
    chk("t4_no_reads", rd_count, 32'd0);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0);

    // Asynchronous reset mid-stream.
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_valid", {31'd0, instr_valid}, 32'd0);
    chk("t5_async_rd", {31'd0, imem_rd}, 32'd0);
    chk("t5_async_instr", instr, 32'd0);
    chk("t5_async_pc", instr_pc, 32'd0);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    step(1, 1, 0, 0);
    chk("t5_restart_addr", obs_addr, RESET_PC);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0);

`ifndef FETCH_BOUNDS_CHK_EN
    // PC wraps modulo 2^32.
    step(1, 1, 1, 32'hFFFF_FFF9);
    chk("wrap_a", obs_addr, 32'hFFFF_FFF8);
    step(1, 1, 0, 0);
    chk("wrap_b", obs_addr, 32'hFFFF_FFFC);
    step(1, 1, 0, 0);
    chk("wrap_c", obs_addr, 32'h0000_0000);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
`else
    // Sequential fetch into the end of the window.
    step(1, 1, 1, 32'h0100_0FF1);
    chk("t6_start_addr", obs_addr, 32'h0100_0FF0);
    rd_count = 0;
    for (int i = 0; i < 7; i++) begin
      step(1, 1, 0, 0);
      if (obs_rd && obs_addr == 32'h0100_1000) rd_count++;
    end
    chk("t6_no_oob_read", rd_count, 32'd0);
    chk("t6_fault_set", {31'd0, fetch_fault}, 32'd1);
    step(1, 1, 1, 32'h0100_0000);
    chk("t6_clear_rd", {31'd0, obs_rd}, 32'd1);
    chk("t6_clear_addr", obs_addr, 32'h0100_0000);
    chk("t6_fault_clear", {31'd0, fetch_fault}, 32'd0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
`endif

    // Randomized traffic against the reference model.
    for (int i = 0; i < 2000; i++) begin
      bit          fe;
      bit          rdy;
      bit          rv;
      logic [31:0] rpc;
      fe  = ($urandom_range(0, 9) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 15) == 0);
      rpc = BASE + 32'($urandom_range(0, 32'h0FFF));
      if ($urandom_range(0, 7) == 0) rpc = BASE + SIZE + 32'($urandom_range(0, 255));
      step(fe, rdy, rv, rpc);
    end
    // Drain what is left.
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
